// File: rtl/wb_arbiter4.sv
// Four-master to one-slave Wishbone arbiter.
// Grant is held for a whole cyc burst; a watchdog ends stalled strobes.
module wb_arbiter4 #(
  parameter bit fixed_prio = 1'b0,
  parameter int timeout    = 255,
  parameter int timeout_w  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  input  logic        m2_cyc_i,
  input  logic        m2_stb_i,
  input  logic        m2_we_i,
  input  logic [31:0] m2_adr_i,
  input  logic [3:0]  m2_sel_i,
  input  logic [31:0] m2_dat_i,
  output logic [31:0] m2_dat_o,
  output logic        m2_ack_o,
  output logic        m2_err_o,
  input  logic        m3_cyc_i,
  input  logic        m3_stb_i,
  input  logic        m3_we_i,
  input  logic [31:0] m3_adr_i,
  input  logic [3:0]  m3_sel_i,
  input  logic [31:0] m3_dat_i,
  output logic [31:0] m3_dat_o,
  output logic        m3_ack_o,
  output logic        m3_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic [3:0]  gnt_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  logic [3:0]       cyc, stb, we;
  logic [3:0][31:0] adr, dat;
  logic [3:0][3:0]  sel;

  assign cyc = {m3_cyc_i, m2_cyc_i, m1_cyc_i, m0_cyc_i};
  assign stb = {m3_stb_i, m2_stb_i, m1_stb_i, m0_stb_i};
  assign we  = {m3_we_i, m2_we_i, m1_we_i, m0_we_i};
  assign adr = {m3_adr_i, m2_adr_i, m1_adr_i, m0_adr_i};
  assign sel = {m3_sel_i, m2_sel_i, m1_sel_i, m0_sel_i};
  assign dat = {m3_dat_i, m2_dat_i, m1_dat_i, m0_dat_i};

  logic [0:0]           state, state_nx;
  logic [3:0]           gnt, gnt_nx;
  logic [1:0]           last, last_nx;
  logic [timeout_w-1:0] cnt, cnt_nx;
  logic                 arb, found, wd_hit, ack_v, err_v;
  logic [1:0]           pick, idx;
  logic [3:0]           ack, err;

  assign arb = (state == IDLE) || ((gnt & cyc) == 4'b0);

  // Round-robin starts one past the last owner; fixed starts at m0.
  always_comb begin
    found = 1'b0;
    pick  = last;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = fixed_prio ? 2'(k) : last + 2'(k + 1);
      if (!found && cyc[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    last_nx  = last;
    if (arb) begin
      if (found) begin
        state_nx = OWN;
        gnt_nx   = 4'b0001 << pick;
        last_nx  = pick;
      end else begin
        state_nx = IDLE;
        gnt_nx   = 4'b0000;
      end
    end
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = 32'h0;
    s_sel_o = 4'h0;
    s_dat_o = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (gnt[i]) begin
        s_cyc_o = cyc[i];
        s_stb_o = stb[i];
        s_we_o  = we[i];
        s_adr_o = adr[i];
        s_sel_o = sel[i];
        s_dat_o = dat[i];
      end
    end
  end

  assign wd_hit = (timeout != 0) && s_stb_o &&
                  (cnt == timeout_w'(timeout));
  // Slave err beats ack; a real ack beats the watchdog.
  assign ack_v  = s_ack_i & ~s_err_i;
  assign err_v  = s_err_i | (wd_hit & ~s_ack_i);
  assign ack    = gnt & {4{ack_v}};
  assign err    = gnt & {4{err_v}};

  always_comb begin
    if ((timeout == 0) || (gnt_nx != gnt) || !s_stb_o ||
        s_ack_i || s_err_i || wd_hit)
      cnt_nx = '0;
    else
      cnt_nx = cnt + timeout_w'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      gnt   <= 4'b0;
      last  <= 2'd3;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
    end
  end

  assign gnt_o    = gnt;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m2_dat_o = s_dat_i;
  assign m3_dat_o = s_dat_i;
  assign m0_ack_o = ack[0];
  assign m1_ack_o = ack[1];
  assign m2_ack_o = ack[2];
  assign m3_ack_o = ack[3];
  assign m0_err_o = err[0];
  assign m1_err_o = err[1];
  assign m2_err_o = err[2];
  assign m3_err_o = err[3];

endmodule

// File: tb/tb_wb_arbiter4.sv
// Bench for wb_arbiter4: directed stimulus pushes expected bus events,
// a negedge monitor pops and compares them against the DUT.
module tb_wb_arbiter4;

  typedef struct packed {
    int unsigned cyc;
    logic [3:0]  g;
    logic [3:0]  a;
    logic [3:0]  e;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]       mcyc, mstb, mwe;
  logic [3:0][31:0] madr, mdat;
  logic [3:0][3:0]  msel;
  logic [31:0]      s_dat_i;
  logic             s_ack, s_err;

  logic [3:0][31:0] r_dat, f_dat;
  logic [3:0]       r_ack, r_err, r_gnt, r_sel;
  logic [3:0]       f_ack, f_err, f_gnt, f_sel;
  logic             r_cyc, r_stb, r_we, f_cyc, f_stb, f_we;
  logic [31:0]      r_adr, r_wdat, f_adr, f_wdat;

  wb_arbiter4 #(.fixed_prio(1'b0), .timeout(4), .timeout_w(8)) u_rr (
    .clk(clk), .reset_n(rst_n),
    .m0_cyc_i(mcyc[0]), .m0_stb_i(mstb[0]), .m0_we_i(mwe[0]),
    .m0_adr_i(madr[0]), .m0_sel_i(msel[0]), .m0_dat_i(mdat[0]),
    .m0_dat_o(r_dat[0]), .m0_ack_o(r_ack[0]), .m0_err_o(r_err[0]),
    .m1_cyc_i(mcyc[1]), .m1_stb_i(mstb[1]), .m1_we_i(mwe[1]),
    .m1_adr_i(madr[1]), .m1_sel_i(msel[1]), .m1_dat_i(mdat[1]),
    .m1_dat_o(r_dat[1]), .m1_ack_o(r_ack[1]), .m1_err_o(r_err[1]),
    .m2_cyc_i(mcyc[2]), .m2_stb_i(mstb[2]), .m2_we_i(mwe[2]),
    .m2_adr_i(madr[2]), .m2_sel_i(msel[2]), .m2_dat_i(mdat[2]),
    .m2_dat_o(r_dat[2]), .m2_ack_o(r_ack[2]), .m2_err_o(r_err[2]),
    .m3_cyc_i(mcyc[3]), .m3_stb_i(mstb[3]), .m3_we_i(mwe[3]),
    .m3_adr_i(madr[3]), .m3_sel_i(msel[3]), .m3_dat_i(mdat[3]),
    .m3_dat_o(r_dat[3]), .m3_ack_o(r_ack[3]), .m3_err_o(r_err[3]),
    .s_cyc_o(r_cyc), .s_stb_o(r_stb), .s_we_o(r_we),
    .s_adr_o(r_adr), .s_sel_o(r_sel), .s_dat_o(r_wdat),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err),
    .gnt_o(r_gnt)
  );

  wb_arbiter4 #(.fixed_prio(1'b1), .timeout(4), .timeout_w(8)) u_fp (
    .clk(clk), .reset_n(rst_n),
    .m0_cyc_i(mcyc[0]), .m0_stb_i(mstb[0]), .m0_we_i(mwe[0]),
    .m0_adr_i(madr[0]), .m0_sel_i(msel[0]), .m0_dat_i(mdat[0]),
    .m0_dat_o(f_dat[0]), .m0_ack_o(f_ack[0]), .m0_err_o(f_err[0]),
    .m1_cyc_i(mcyc[1]), .m1_stb_i(mstb[1]), .m1_we_i(mwe[1]),
    .m1_adr_i(madr[1]), .m1_sel_i(msel[1]), .m1_dat_i(mdat[1]),
    .m1_dat_o(f_dat[1]), .m1_ack_o(f_ack[1]), .m1_err_o(f_err[1]),
    .m2_cyc_i(mcyc[2]), .m2_stb_i(mstb[2]), .m2_we_i(mwe[2]),
    .m2_adr_i(madr[2]), .m2_sel_i(msel[2]), .m2_dat_i(mdat[2]),
    .m2_dat_o(f_dat[2]), .m2_ack_o(f_ack[2]), .m2_err_o(f_err[2]),
    .m3_cyc_i(mcyc[3]), .m3_stb_i(mstb[3]), .m3_we_i(mwe[3]),
    .m3_adr_i(madr[3]), .m3_sel_i(msel[3]), .m3_dat_i(mdat[3]),
    .m3_dat_o(f_dat[3]), .m3_ack_o(f_ack[3]), .m3_err_o(f_err[3]),
    .s_cyc_o(f_cyc), .s_stb_o(f_stb), .s_we_o(f_we),
    .s_adr_o(f_adr), .s_sel_o(f_sel), .s_dat_o(f_wdat),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err),
    .gnt_o(f_gnt)
  );

  int unsigned cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  ev_t        q[$];
  logic       sel_fp = 1'b0;
  logic       mon_en = 1'b0;
  logic [3:0] prev_g = 4'b0;
  int         nchk = 0;
  int         nfail = 0;

  // An event is a grant change or any ack/err pulse.
  always @(negedge clk) begin
    ev_t o, x;
    o.cyc = cyc_n;
    o.g   = sel_fp ? f_gnt : r_gnt;
    o.a   = sel_fp ? f_ack : r_ack;
    o.e   = sel_fp ? f_err : r_err;
    if (mon_en && (o.g != prev_g || |o.a || |o.e)) begin
      nchk++;
      if (q.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_event: cyc=%0d gnt=%b ack=%b err=%b, none required",
                 o.cyc, o.g, o.a, o.e);
      end else begin
        x = q.pop_front();
        if (o !== x) begin
          nfail++;
          $display("FAIL event: got cyc=%0d gnt=%b ack=%b err=%b, required cyc=%0d gnt=%b ack=%b err=%b",
                   o.cyc, o.g, o.a, o.e, x.cyc, x.g, x.a, x.e);
        end
      end
    end
    prev_g <= o.g;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int unsigned c, input logic [3:0] g,
                      input logic [3:0] a, input logic [3:0] e);
    ev_t x;
    x.cyc = c;
    x.g   = g;
    x.a   = a;
    x.e   = e;
    q.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mcyc  = '0;
    mstb  = '0;
    mwe   = '0;
    madr  = '0;
    msel  = '0;
    mdat  = '0;
    s_ack = 1'b0;
    s_err = 1'b0;
  endtask

  task automatic req(input int i, input logic v, input logic [31:0] a);
    mcyc[i] = v;
    mstb[i] = v;
    mwe[i]  = v & i[0];
    madr[i] = a;
    msel[i] = v ? 4'hf : 4'h0;
    mdat[i] = a ^ 32'h5a5a_5a5a;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL run_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned c, s;
    rst_n   = 1'b0;
    s_dat_i = 32'hcafe_f00d;
    idle_inputs();
    req(0, 1'b1, 32'hdead_beef);
    s_ack = 1'b1;
    s_err = 1'b1;
    tick();
    tick();
    chk("rst_gnt", r_gnt, 0);
    chk("rst_s_cyc", r_cyc, 0);
    chk("rst_s_stb", r_stb, 0);
    chk("rst_s_adr", r_adr, 0);
    chk("rst_s_sel", r_sel, 0);
    chk("rst_s_dat", r_wdat, 0);
    chk("rst_ack", r_ack, 0);
    chk("rst_err", r_err, 0);
    idle_inputs();
    mon_en = 1'b1;
    rst_n  = 1'b1;

    // single request from m1
    c = cyc_n;
    req(1, 1'b1, 32'h4000_0010);
    push(c + 1, 4'b0010, 4'b0, 4'b0);
    tick();
    chk("t1_s_adr", r_adr, 32'h4000_0010);
    chk("t1_s_cyc", r_cyc, 1);
    chk("t1_s_we", r_we, 1);
    chk("t1_s_dat", r_wdat, 32'h4000_0010 ^ 32'h5a5a_5a5a);
    chk("t1_bcast", r_dat[2], 32'hcafe_f00d);
    tick();
    s_ack = 1'b1;
    push(c + 2, 4'b0010, 4'b0010, 4'b0);
    #1 chk("t1_ack", r_ack, 4'b0010);
    tick();
    s_ack = 1'b0;
    req(1, 1'b0, 0);
    push(c + 4, 4'b0, 4'b0, 4'b0);
    tick();
    tick();

    // round-robin fairness
    do_reset();
    for (int i = 0; i < 4; i++) req(i, 1'b1, 32'h1000_0000 + i);
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k > 0) req((k - 1) % 4, 1'b1, 32'h1000_0000 + k);
      s_ack = 1'b1;
      push(cyc_n, 4'b0001 << (k % 4), 4'b0001 << (k % 4), 4'b0);
      tick();
      s_ack = 1'b0;
      req(k % 4, 1'b0, 0);
    end
    idle_inputs();
    push(cyc_n + 1, 4'b0, 4'b0, 4'b0);
    tick();
    tick();

    // fixed priority, no preemption
    rst_n  = 1'b0;
    sel_fp = 1'b1;
    do_reset();
    c = cyc_n;
    req(3, 1'b1, 32'h3000_0000);
    push(c + 1, 4'b1000, 4'b0, 4'b0);
    tick();
    req(0, 1'b1, 32'h0000_0040);
    req(2, 1'b1, 32'h2000_0040);
    tick();
    s_ack = 1'b1;
    push(c + 2, 4'b1000, 4'b1000, 4'b0);
    tick();
    s_ack = 1'b0;
    tick();
    s_ack = 1'b1;
    push(c + 4, 4'b1000, 4'b1000, 4'b0);
    chk("t3_hold", f_gnt, 4'b1000);
    tick();
    s_ack = 1'b0;
    req(3, 1'b0, 0);
    tick();
    s_ack = 1'b1;
    push(c + 6, 4'b0001, 4'b0001, 4'b0);
    chk("t3_m0_adr", f_adr, 32'h0000_0040);
    tick();
    s_ack = 1'b0;
    req(0, 1'b0, 0);
    tick();
    s_ack = 1'b1;
    push(c + 8, 4'b0100, 4'b0100, 4'b0);
    tick();
    s_ack = 1'b0;
    req(2, 1'b0, 0);
    push(c + 10, 4'b0, 4'b0, 4'b0);
    tick();
    tick();

    // watchdog: stalled strobe, then ack in the timeout cycle
    rst_n  = 1'b0;
    sel_fp = 1'b0;
    do_reset();
    c = cyc_n;
    mcyc[2] = 1'b1;
    madr[2] = 32'h2000_0000;
    push(c + 1, 4'b0100, 4'b0, 4'b0);
    tick();
    mstb[2] = 1'b1;
    s = cyc_n;
    push(s + 4, 4'b0100, 4'b0, 4'b0100);
    repeat (4) tick();
    chk("t4_wd_err", r_err, 4'b0100);
    tick();
    mstb[2] = 1'b0;
    tick();
    mstb[2] = 1'b1;
    repeat (4) tick();
    s_ack = 1'b1;
    push(s + 10, 4'b0100, 4'b0100, 4'b0);
    #1 chk("t4_ack_wins", r_err, 4'b0);
    tick();
    s_ack   = 1'b0;
    mcyc[2] = 1'b0;
    mstb[2] = 1'b0;
    push(s + 12, 4'b0, 4'b0, 4'b0);
    tick();
    tick();

    // reset mid-burst
    do_reset();
    c = cyc_n;
    req(0, 1'b1, 32'h0000_0100);
    push(c + 1, 4'b0001, 4'b0, 4'b0);
    tick();
    tick();
    s_ack = 1'b1;
    #1 chk("t5_ack_pre", r_ack, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("t5_s_cyc", r_cyc, 0);
    chk("t5_gnt", r_gnt, 0);
    chk("t5_ack", r_ack, 0);
    req(1, 1'b1, 32'h0000_0200);
    s_ack = 1'b0;
    rst_n = 1'b1;
    push(c + 2, 4'b0, 4'b0, 4'b0);
    push(c + 3, 4'b0001, 4'b0, 4'b0);
    tick();
    req(0, 1'b0, 0);
    push(c + 4, 4'b0010, 4'b0, 4'b0);
    tick();
    req(1, 1'b0, 0);
    push(c + 5, 4'b0, 4'b0, 4'b0);
    tick();
    tick();

    // slave err and ack together
    c = cyc_n;
    req(1, 1'b1, 32'h4000_0020);
    push(c + 1, 4'b0010, 4'b0, 4'b0);
    tick();
    tick();
    s_ack = 1'b1;
    s_err = 1'b1;
    push(c + 2, 4'b0010, 4'b0, 4'b0010);
    #1;
    chk("t6_ack", r_ack, 4'b0);
    chk("t6_err", r_err, 4'b0010);
    tick();
    s_ack = 1'b0;
    s_err = 1'b0;
    req(1, 1'b0, 0);
    push(c + 4, 4'b0, 4'b0, 4'b0);
    tick();
    tick();

    chk("events_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter4.md
Name: wb_arbiter4

Overview:
- Four-master to one-slave Wishbone arbiter. It shares one slave bus (for example the SRAM or a peripheral sub-bus) among the LM32 instruction port, the LM32 data port and up to two extra masters (DMA, debug).
- Supports round-robin or fixed priority.
- The grant is held for a whole `cyc` burst.
- A bus watchdog ends stuck transfers with `err`.

Parameters:
- fixed_prio, 0, 0 = round-robin, 1 = fixed priority (m0 highest, m3 lowest)
- timeout, 255, number of stalled strobe cycles before the watchdog fires; 0 disables the watchdog
- timeout_w, 8, width of the watchdog counter; timeout must be < 2**timeout_w

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m0..m3_cyc_i  in  1 each  master cycle request
- m0..m3_stb_i  in  1 each  master strobe
- m0..m3_we_i  in  1 each  master write enable
- m0..m3_adr_i  in  32 each  master address
- m0..m3_sel_i  in  4 each  master byte selects
- m0..m3_dat_i  in  32 each  master write data
- m0..m3_dat_o  out  32 each  read data (s_dat_i broadcast to all masters)
- m0..m3_ack_o  out  1 each  acknowledge, owner only
- m0..m3_err_o  out  1 each  error (slave err or watchdog), owner only
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave control
- s_adr_o  out  32  slave address
- s_sel_o  out  4  slave byte selects
- s_dat_o  out  32  slave write data
- s_dat_i  in  32  slave read data
- s_ack_i, s_err_i  in  1 each  slave response
- gnt_o  out  4  one-hot current owner; 0 when idle

Behaviour:

State machine (states IDLE and OWN):
- `reset_n` low (asynchronous): state goes to IDLE, `gnt_o` = 0, the round-robin pointer `last` = 3, the watchdog counter = 0.
- While `gnt_o` = 0:
  - all slave control outputs are 0;
  - `s_adr_o`, `s_sel_o` and `s_dat_o` are 0;
  - all `mi_ack_o` and `mi_err_o` are 0.

Arbitration:
- Takes place at a clock edge when the state is IDLE, or when the state is OWN and the owner's `cyc_i` is low.
- Candidates are the masters with `cyc_i` high.
- Round-robin search order is last+1, last+2, last+3, last (mod 4).
- Fixed-priority search order is 0, 1, 2, 3.
- The first candidate found becomes the owner: `gnt_o` is set and `last` is updated. If there is no candidate, the state goes to IDLE.
- Latency: a request seen at edge N is granted from cycle N+1. The slave sees `cyc` no earlier than one cycle after the master raises it.
- Handover: if the owner drops `cyc` in cycle N and another master is requesting, the new owner is granted in cycle N+1 with no idle gap.

Grant hold and muxing:
- The grant is never revoked while the owner's `cyc_i` stays high. There is no preemption.
- Slave outputs are combinational muxes of the owner's inputs: `s_cyc_o` = owner `cyc`, `s_stb_o` = owner `stb`, and likewise for `we`, `adr`, `sel` and `dat`.
- Owner `ack_o` = `s_ack_i`.
- Non-owners: `ack_o` and `err_o` are 0; their `stb` is ignored (they wait).

Watchdog (active when timeout > 0):
- The counter increments each cycle that `s_stb_o` = 1 and `s_ack_i` = `s_err_i` = 0.
- The counter clears on `ack`, on `err`, when `stb` is low, and on any grant change.
- When the count equals timeout, owner `err_o` = 1 for that one cycle and the counter clears.
- `s_err_i` is also passed to owner `err_o`.
- If `s_ack_i` is asserted in the same cycle as the timeout, `ack` wins: no `err`, and the counter clears.
- `ack` and `err` are never asserted together to a master. If the slave asserts both, only `err` is passed.

Reset and reserved masters:
- `reset_n` asserted mid-burst: outputs drop to idle values immediately (asynchronously). After release, arbitration restarts from m0 priority.
- Unused master ports tied to 0 are never granted.

Test Plan:
1. Single request: m1 raises `cyc`/`stb` with adr 0x4000_0010, and the slave acks 2 cycles later. Required response: `gnt_o` = 0010 one cycle after request; `s_adr_o` = 0x4000_0010; m1_ack_o pulses one cycle; m0/m2/m3 `ack` stay 0.
2. Round-robin fairness: all four masters hold `cyc` and each drops it after 1 acked access, then re-raises it. Required grant order after reset: 0, 1, 2, 3, 0, with no idle cycle between owners.
3. Fixed priority (fixed_prio = 1): m3 is the owner; m0 and m2 request while m3 is mid-burst. m3 keeps the grant until its `cyc` drops, then m0 is granted, then m2.
4. Watchdog (timeout = 4): m2 strobes and the slave never acks. m2_err_o = 1 exactly 4 cycles after `stb` rises, for 1 cycle. Repeat with `ack` arriving in the 4th cycle: `ack` only, no `err`.
5. Reset mid-burst: m0 is owner with `stb` high, and `reset_n` is pulsed low between edges. `s_cyc_o`, `gnt_o` and m0_ack_o go to 0 immediately. After release with m1 and m0 both requesting, m0 is granted first.
6. Slave error: `s_err_i` and `s_ack_i` are both high in the same cycle for owner m1. m1_err_o = 1 and m1_ack_o = 0.
